fifo_reg16: RTL and testbench

FIFO_REG16 -- requirements
Module: fifo_reg16

---
 rtl/fifo_reg16_pkg.sv | 11 +
 rtl/fifo_reg16_ptr_counter.sv | 14 +
 rtl/fifo_reg16.sv | 46 ++++
 tb/tb_fifo_reg16.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fifo_reg16_pkg.sv
// fifo_reg16_pkg: shared memory defaults (WIDTH 16, DEPTH 8) and the log2 helper used to size pointers
package fifo_reg16_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_reg16_ptr_counter.sv
// ptr_counter: AW-bit wrapping pointer; clock, reset_n (sync active-low), increment advances out by one mod 2**AW
module ptr_counter #(
  parameter int AW = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          increment,
  output logic [AW-1:0] out
);
  always_ff @(posedge clock) begin
    if (!reset_n) out <= '0;
    else if (increment) out <= out + 1'b1;
  end
endmodule

// File: rtl/fifo_reg16.sv
// fifo_reg16: first-word-fall-through register FIFO; push/in write, pop/out head, full/empty/count status, sticky overflow/underflow
module fifo_reg16
  import fifo_reg16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = log2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] in,
  input  logic             pop,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & (~full | pop);
  assign do_pop = pop & ~empty;
  assign out = mem[rd_ptr];
  ptr_counter #(.AW(AW)) u_wr (.clock(clock), .reset_n(reset_n), .increment(do_push), .out(wr_ptr));
  ptr_counter #(.AW(AW)) u_rd (.clock(clock), .reset_n(reset_n), .increment(do_pop), .out(rd_ptr));
  always_ff @(posedge clock) begin
    for (int k = 0; k < DEPTH; k++)
      if (do_push && wr_ptr == AW'(k)) mem[k] <= in;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= (do_push & ~do_pop) ? count + 1'b1 : (do_pop & ~do_push) ? count - 1'b1 : count;
      if (push & full & ~pop) overflow <= 1'b1;
      if (pop & empty & ~push) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_reg16.sv
// tb_fifo_reg16: scoreboard bench for fifo_reg16 covering reset, fill/drain, overflow, underflow, simultaneous ops, wrap, mid-run reset
module tb_fifo_reg16;
  localparam int W = 16;
  localparam int D = 8;
  logic clock = 0, reset_n = 0, push = 0, pop = 0;
  logic [W-1:0] in = '0;
  logic [W-1:0] out;
  logic full, empty, overflow, underflow;
  logic [3:0] count;
  int checks = 0, errors = 0;
  logic [W-1:0] exp_q[$];
  always #5 clock = ~clock;
  fifo_reg16 dut (
    .clock(clock), .reset_n(reset_n), .push(push), .in(in), .pop(pop), .out(out),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );
  task automatic drive(input logic r, input logic p, input logic [W-1:0] d, input logic q);
    bit pa, qa;
    reset_n = r; push = p; in = d; pop = q;
    pa = p && (exp_q.size() < D || q);
    qa = q && exp_q.size() > 0;
    if (!r) exp_q.delete();
    else begin
      if (qa) void'(exp_q.pop_front());
      if (pa) exp_q.push_back(d);
    end
    @(posedge clock); #1;
    reset_n = 1; push = 0; pop = 0;
  endtask
  task automatic test_reset;
    drive(0, 1, 16'h5555, 1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow); end
  endtask
  task automatic test_fill_drain;
    drive(0, 0, '0, 0);
    for (int i = 1; i <= 8; i++) drive(1, 1, W'(i), 0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", count); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (out !== exp_q[0] || out !== W'(i)) begin errors++; $display("FAIL drain_out got %h exp %h", out, W'(i)); end
      drive(1, 0, '0, 1);
    end
    checks++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty, count); end
  endtask
  task automatic test_overflow;
    for (int i = 1; i <= 8; i++) drive(1, 1, W'(i), 0);
    drive(1, 1, 16'hDEAD, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", count); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (out !== exp_q[0] || out !== W'(i)) begin errors++; $display("FAIL ovf_drain got %h exp %h", out, W'(i)); end
      drive(1, 0, '0, 1);
    end
    checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got empty=%b ovf=%b exp 1/1", empty, overflow); end
  endtask
  task automatic test_underflow;
    drive(0, 0, '0, 0);
    drive(1, 0, '0, 1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", underflow); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL unf_count got %0d exp 0", count); end
    drive(1, 1, 16'h1234, 0);
    checks++; if (out !== 16'h1234) begin errors++; $display("FAIL unf_fwft got %h exp 1234", out); end
    checks++; if (underflow !== 1'b1 || count !== 4'd1) begin errors++; $display("FAIL unf_sticky got unf=%b count=%0d exp 1/1", underflow, count); end
    drive(1, 0, '0, 1);
  endtask
  task automatic test_simultaneous;
    drive(0, 0, '0, 0);
    for (int i = 0; i < 8; i++) drive(1, 1, W'(16'h0100 + i), 0);
    checks++; if (out !== exp_q[0]) begin errors++; $display("FAIL sim_head got %h exp %h", out, exp_q[0]); end
    drive(1, 1, 16'hAAAA, 1);
    checks++; if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL sim_full got count=%0d full=%b ovf=%b exp 8/1/0", count, full, overflow); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (out !== exp_q[0]) begin errors++; $display("FAIL sim_drain got %h exp %h", out, exp_q[0]); end
      drive(1, 0, '0, 1);
    end
    checks++; if (out !== 16'hAAAA) begin errors++; $display("FAIL sim_last got %h exp aaaa", out); end
    drive(1, 0, '0, 1);
    drive(1, 1, 16'hBEEF, 1);
    checks++; if (count !== 4'd1 || underflow !== 1'b0 || out !== 16'hBEEF) begin errors++; $display("FAIL sim_empty got count=%0d unf=%b out=%h exp 1/0/beef", count, underflow, out); end
    drive(1, 0, '0, 1);
  endtask
  task automatic test_wrap;
    drive(0, 0, '0, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, W'(16'hC000 + i), 0);
    for (int i = 0; i < 20; i++) begin
      checks++; if (out !== exp_q[0]) begin errors++; $display("FAIL wrap_out got %h exp %h", out, exp_q[0]); end
      drive(1, 1, W'(16'hD000 + i), 1);
    end
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL wrap_count got %0d exp 3", count); end
    for (int i = 17; i < 20; i++) begin
      checks++; if (out !== W'(16'hD000 + i)) begin errors++; $display("FAIL wrap_tail got %h exp %h", out, W'(16'hD000 + i)); end
      drive(1, 0, '0, 1);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
  endtask
  task automatic test_reset_mid;
    drive(0, 0, '0, 0);
    drive(1, 0, '0, 1);
    for (int i = 0; i < 9; i++) drive(1, 1, W'(16'hE000 + i), 0);
    for (int i = 0; i < 3; i++) drive(1, 0, '0, 1);
    checks++; if (count !== 4'd5 || overflow !== 1'b1 || underflow !== 1'b1) begin errors++; $display("FAIL mid_pre got count=%0d ovf=%b unf=%b exp 5/1/1", count, overflow, underflow); end
    drive(0, 1, 16'hFFFF, 0);
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_count got count=%0d empty=%b exp 0/1", count, empty); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL mid_flags got ovf=%b unf=%b exp 0/0", overflow, underflow); end
  endtask
  initial begin
    test_reset;
    test_fill_drain;
    test_overflow;
    test_underflow;
    test_simultaneous;
    test_wrap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
